// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and helpers
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with a registered head entry
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_empty;

  logic [AW-1:0]    w_rd_ptr_n;
  logic [AW:0]      w_count_n;
  logic [WIDTH-1:0] w_head_n;
  logic             w_do_pop;
  logic             w_do_push;

  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign empty_o   = r_empty;
  assign head_o    = r_head;
  assign w_do_pop  = pop_i & ~r_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = push_i & (~full_o | w_do_pop);

  // Next read pointer, occupancy and head; a push into an emptying FIFO bypasses memory.
  always_comb begin
    w_rd_ptr_n = r_rd_ptr + AW'(w_do_pop);
    w_count_n  = r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    w_head_n   = r_mem[w_rd_ptr_n];
    if (w_count_n == '0) begin
      w_head_n = '0;
    end else if (w_do_push && (r_count == (AW+1)'(w_do_pop))) begin
      w_head_n = push_data_i;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= w_count_n;
      r_head   <= w_head_n;
      r_empty  <= (w_count_n == '0);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with output FIFO; UART_RX_MAJORITY_EN selects 3-sample voting
module uart_rx
  import uart_pkg::*;
#(
  parameter int FREQ       = 460800,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CPB = clks_per_bit(FREQ, BAUD);
  localparam int MID = CPB / 2;
  localparam int CW  = $clog2(CPB);
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP = MID + 1;
`else
  localparam int SAMP = MID;
`endif
  localparam logic PAR_EN  = (PARITY != int'(PAR_NONE));
  localparam logic PAR_EXP = (PARITY == int'(PAR_ODD));

  generate
    if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_rx: illegal parameter set");
    end
  endgenerate

  typedef struct packed {
    logic                 parity_err;
    logic                 frame_err;
    logic [DATA_BITS-1:0] data;
  } rx_entry_t;

  rx_state_e            r_state;
  rx_state_e            w_state_n;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync3;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_ferr;
  logic                 r_par;
  logic                 r_overrun;

  logic                 w_fall;
  logic                 w_bit;
  logic                 w_sample;
  logic                 w_last_stop;
  logic                 w_push;
  rx_entry_t            w_entry;
  rx_entry_t            w_head;
  logic                 w_empty;
  logic                 w_full;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_fall = r_sync3 & ~r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic r_maj_a;
  logic r_maj_b;

  // Capture the two early votes; the third is the live sample at the decision point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_maj_a <= 1'b1;
      r_maj_b <= 1'b1;
    end else begin
      if (r_cnt == CW'(MID - 1)) r_maj_a <= r_sync2;
      if (r_cnt == CW'(MID))     r_maj_b <= r_sync2;
    end
  end

  assign w_bit = (r_maj_a & r_maj_b) | (r_maj_a & r_sync2) | (r_maj_b & r_sync2);
`else
  assign w_bit = r_sync2;
`endif

  assign w_sample    = (r_cnt == CW'(SAMP));
  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

  // Bit-period counter; held at zero while idle so each frame starts aligned to its edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == IDLE) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(CPB - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state logic; the push fires on the last stop-bit sample without waiting for bit end.
  always_comb begin
    w_state_n = r_state;
    w_push    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) w_state_n = START;
      end
      START: begin
        if (w_sample) w_state_n = w_bit ? IDLE : DATA;
      end
      DATA: begin
        if (w_sample && r_bit_idx == 4'(DATA_BITS - 1)) begin
          w_state_n = PAR_EN ? uart_pkg::PARITY : STOP;
        end
      end
      uart_pkg::PARITY: begin
        if (w_sample) w_state_n = STOP;
      end
      STOP: begin
        if (w_sample && w_last_stop) begin
          w_push    = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Frame datapath: shift in data LSB first, capture parity, accumulate stop-bit errors.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_ferr     <= 1'b0;
      r_par      <= 1'b0;
    end else begin
      case (r_state)
        START: begin
          r_bit_idx  <= '0;
          r_stop_idx <= 1'b0;
          r_ferr     <= 1'b0;
        end
        DATA: begin
          if (w_sample) begin
            r_data    <= {w_bit, r_data[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 4'd1;
          end
        end
        uart_pkg::PARITY: begin
          if (w_sample) r_par <= w_bit;
        end
        STOP: begin
          if (w_sample) begin
            r_ferr     <= r_ferr | ~w_bit;
            r_stop_idx <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Entry assembled from the live last stop sample so the push needs no extra cycle.
  always_comb begin
    w_entry            = '0;
    w_entry.data       = r_data;
    w_entry.frame_err  = r_ferr | ~w_bit;
    w_entry.parity_err = PAR_EN & ((^r_data ^ r_par) != PAR_EXP);
  end

  sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_entry),
    .pop_i       (ready_i),
    .head_o      (w_head),
    .empty_o     (w_empty),
    .full_o      (w_full)
  );

  // Overrun pulse: a frame completed into a full FIFO that is not draining this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_overrun <= 1'b0;
    else       r_overrun <= w_push & w_full & ~(~w_empty & ready_i);
  end

  assign data_o       = w_head.data;
  assign frame_err_o  = w_head.frame_err;
  assign parity_err_o = w_head.parity_err;
  assign valid_o      = ~w_empty;
  assign overrun_o    = r_overrun;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (8N1 and 8E1 instances)
module tb_uart_rx;

  localparam int CPB = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int VOTE = 1;
`else
  localparam int VOTE = 0;
`endif
  // Line edge to valid_o: 2 sync flops + edge register, half a bit to the start
  // sample, 9 more bit periods to the stop sample, then the registered push.
  localparam int LAT_A = 3 + CPB / 2 + CPB * 9 + 1 + VOTE;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic       ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       ferr_a, ferr_b, perr_a, perr_b;
  logic       valid_a, valid_b, ovr_a, ovr_b, busy_a, busy_b;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         rise_cyc = -1;
  int         ovr_hi_a = 0;
  logic       valid_a_q = 1'b0;
  logic [9:0] sb_a[$];
  logic [9:0] sb_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx u_dut_a (
    .clk_i(clk), .rst_i(rst), .uart_rx_i(rx_a), .data_o(data_a),
    .frame_err_o(ferr_a), .parity_err_o(perr_a), .valid_o(valid_a),
    .ready_i(ready_a), .overrun_o(ovr_a), .busy_o(busy_a)
  );

  uart_rx #(.PARITY(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .uart_rx_i(rx_b), .data_o(data_b),
    .frame_err_o(ferr_b), .parity_err_o(perr_b), .valid_o(valid_b),
    .ready_i(ready_b), .overrun_o(ovr_b), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard pop for each instance whenever the DUT hands over its head entry.
  always @(negedge clk) begin : mon_a
    logic [9:0] e;
    if (!rst && valid_a && ready_a) begin
      if (sb_a.size() == 0) begin
        check("a_unexpected_entry", {22'd0, perr_a, ferr_a, data_a}, 32'hFFFF_FFFF);
      end else begin
        e = sb_a.pop_front();
        check("a_data", data_a, e[7:0]);
        check("a_frame_err", ferr_a, e[8]);
        check("a_parity_err", perr_a, e[9]);
      end
    end
    if (valid_a && !valid_a_q) rise_cyc = cyc;
    valid_a_q = valid_a;
    if (ovr_a) ovr_hi_a++;
  end

  always @(negedge clk) begin : mon_b
    logic [9:0] e;
    if (!rst && valid_b && ready_b) begin
      if (sb_b.size() == 0) begin
        check("b_unexpected_entry", {22'd0, perr_b, ferr_b, data_b}, 32'hFFFF_FFFF);
      end else begin
        e = sb_b.pop_front();
        check("b_data", data_b, e[7:0]);
        check("b_frame_err", ferr_b, e[8]);
        check("b_parity_err", perr_b, e[9]);
      end
    end
  end

  task automatic line_bit(input bit b_sel, input logic v);
    if (b_sel) rx_b = v;
    else       rx_a = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit b_sel, input logic [7:0] d, input bit with_par,
                            input logic par_bit, input logic stop_v);
    line_bit(b_sel, 1'b0);
    for (int i = 0; i < 8; i++) line_bit(b_sel, d[i]);
    if (with_par) line_bit(b_sel, par_bit);
    line_bit(b_sel, stop_v);
    line_bit(b_sel, 1'b1);
  endtask

  task automatic drain(input bit b_sel);
    if (b_sel) ready_b = 1'b1;
    else       ready_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (b_sel ? (sb_b.size() == 0 && !valid_b) : (sb_a.size() == 0 && !valid_a)) break;
    end
    check(b_sel ? "b_drain_left" : "a_drain_left", b_sel ? sb_b.size() : sb_a.size(), 0);
    check(b_sel ? "b_valid_after_drain" : "a_valid_after_drain", b_sel ? valid_b : valid_a, 0);
    if (b_sel) ready_b = 1'b0;
    else       ready_a = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_data", data_a, 0);
    check("rst_flags", {ferr_a, perr_a}, 0);
    check("rst_b_valid", valid_b, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 0xA5 8N1 with latency measurement
    rise_cyc = -1;
    n = cyc;
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    sb_a.push_back({2'b00, 8'hA5});
    check("a5_latency", rise_cyc - n, LAT_A);
    check("a5_valid_held", valid_a, 1);
    drain(0);

    // Even parity: 0x07 with parity 1 is good, with parity 0 is bad
    send_frame(1, 8'h07, 1, 1'b1, 1'b1);
    sb_b.push_back({2'b00, 8'h07});
    send_frame(1, 8'h07, 1, 1'b0, 1'b1);
    sb_b.push_back({2'b10, 8'h07});
    drain(1);

    // Low stop bit then a clean frame
    send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
    sb_a.push_back({2'b01, 8'h3C});
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    sb_a.push_back({2'b00, 8'h11});
    drain(0);

    // Five frames into a four-entry FIFO with no consumer
    check("no_overrun_yet", ovr_hi_a, 0);
    ovr_hi_a = 0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d;
      d = 8'(8'h21 + i * 8'h13);
      send_frame(0, d, 0, 1'b0, 1'b1);
      if (i < 4) sb_a.push_back({2'b00, d});
    end
    check("overrun_cycles", ovr_hi_a, 1);
    check("full_valid", valid_a, 1);
    drain(0);

    // One-cycle glitch on the idle line
    rx_a = 1'b0;
    @(posedge clk);
    #1;
    rx_a = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && !busy_a; i++) @(negedge clk);
    check("glitch_busy_seen", busy_a, 1);
    while (busy_a && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("glitch_busy_len_ok", n <= CPB / 2 + 1 + VOTE, 1);
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("glitch_no_push", valid_a, 0);

    // Reset mid-frame with two entries queued
    send_frame(0, 8'h66, 0, 1'b0, 1'b1);
    send_frame(0, 8'h99, 0, 1'b0, 1'b1);
    check("pre_rst_valid", valid_a, 1);
    line_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) line_bit(0, 1'b1);
    check("pre_rst_busy", busy_a, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", valid_a, 0);
    check("post_rst_busy", busy_a, 0);
    rst = 1'b0;
    line_bit(0, 1'b1);
    send_frame(0, 8'h55, 0, 1'b0, 1'b1);
    sb_a.push_back({2'b00, 8'h55});
    drain(0);

    check("final_sb_a", sb_a.size(), 0);
    check("final_sb_b", sb_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
